fwd_hazard_unit: RTL

- Parametrised forwarding and hazard unit for the RV32I in-order pipeline.
- Tracks in-flight register writers in an internal scoreboard shift register.
- Produces per-source forward selects and the load-use stall for the instruction in ID.
- Supports configurable forwarding depth, source count and load latency, and counts stall cycles.

---
 rtl/fwd_hazard_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: a scoreboard of in-flight register writers
// drives per-source forward selects and the load-use stall for the ID instruction.
module fwd_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      pipe_hold,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [31:0]               stall_count
);

    // Slot 0 is the instruction in EX; slot k is k stages past EX.
    logic [FWD_DEPTH:0] slot_valid;
    logic [FWD_DEPTH:0] slot_load;
    logic [REG_AW-1:0]  slot_rd [0:FWD_DEPTH];

    logic               stall_raw;
    logic               found;
    logic [SEL_W-1:0]   sel;
    logic [REG_AW-1:0]  src;

    function automatic logic src_match(input logic v, input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] s, input logic used);
        return v && (rd != '0) && (rd == s) && used;
    endfunction

    always_comb begin
        fwd_sel   = '0;
        stall_raw = 1'b0;
        found     = 1'b0;
        sel       = '0;
        src       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src   = id_src[i*REG_AW +: REG_AW];
            found = 1'b0;
            sel   = '0;
            // Youngest matching producer wins; a too-young load still owns the select.
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                if (!found && src_match(slot_valid[k], slot_rd[k], src, id_src_used[i])) begin
                    found = 1'b1;
                    sel   = k[SEL_W-1:0];
                    if (slot_load[k] && (k < LOAD_STAGE))
                        stall_raw = 1'b1;
                end
            end
            if (slot_load[0] && src_match(slot_valid[0], slot_rd[0], src, id_src_used[i]))
                stall_raw = 1'b1;
            fwd_sel[i*SEL_W +: SEL_W] = sel;
        end
        stall = id_valid && stall_raw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid  <= '0;
            slot_load   <= '0;
            for (int k = 0; k <= FWD_DEPTH; k++)
                slot_rd[k] <= '0;
            stall_count <= '0;
        end else if (!pipe_hold) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_load[k]  <= slot_load[k-1];
                slot_rd[k]    <= slot_rd[k-1];
            end
            // A stalled, flushed or empty ID slot becomes a bubble in EX.
            if (flush || stall || !id_valid) begin
                slot_valid[0] <= 1'b0;
                slot_load[0]  <= 1'b0;
            end else begin
                slot_valid[0] <= id_we && (id_rd != '0);
                slot_load[0]  <= id_is_load;
                slot_rd[0]    <= id_rd;
            end
            if (stall && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end else if (flush) begin
            slot_valid[0] <= 1'b0;
            slot_load[0]  <= 1'b0;
        end
    end

endmodule
